// File: rtl/spi_controller.sv
// SPI mode-0 initiator that issues 16-bit {rw, addr[6:0], data[7:0]} frames MSB first
// and captures CIPO during the data byte. One command is accepted per valid/ready
// handshake while idle; all pin and status outputs are registered.
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_rw_i,
    input  logic [6:0] cmd_addr_i,
    input  logic [7:0] cmd_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rsp_data_o,
    output logic       SCLK_o,
    output logic       nCS_o,
    output logic       COPI_o,
    input  logic       CIPO_i
);

    // The shift counter spans a whole bit (low + high phase), so it sets the width floor.
    localparam int BIT_CYCLES = 2 * CLK_DIV;
    localparam int MAX_AB     = (BIT_CYCLES > CS_SETUP) ? BIT_CYCLES : CS_SETUP;
    localparam int MAX_CD     = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAX_CNT    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitIdx_q, bitIdx_d;
    logic [15:0]      frame_q, frame_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [7:0]       rsp_q, rsp_d;
    logic             sclk_q, sclk_d;
    logic             ncs_q, ncs_d;
    logic             copi_q, copi_d;
    logic             done_q, done_d;
    logic             ready_q;
    logic             busy_q;

    // Next-state and next-pin-level logic; pins are computed one cycle ahead so they can be registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        frame_d  = frame_q;
        shadow_d = shadow_q;
        rsp_d    = rsp_q;
        sclk_d   = sclk_q;
        ncs_d    = ncs_q;
        copi_d   = copi_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    frame_d  = {cmd_rw_i, cmd_addr_i, cmd_data_i};
                    bitIdx_d = 4'd15;
                    shadow_d = 8'd0;
                    cnt_d    = CNT_W'(CS_SETUP - 1);
                    ncs_d    = 1'b0;
                    sclk_d   = 1'b0;
                    copi_d   = cmd_rw_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(BIT_CYCLES - 1);
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                // Counter runs 2*CLK_DIV-1 down to 0: upper half is SCLK low, lower half SCLK high.
                if (cnt_q == '0) begin
                    sclk_d = 1'b0;
                    if (bitIdx_q == 4'd0) begin
                        cnt_d   = CNT_W'(CS_HOLD - 1);
                        state_d = HOLD;
                    end else begin
                        bitIdx_d = bitIdx_q - 4'd1;
                        copi_d   = frame_q[bitIdx_q - 4'd1];
                        cnt_d    = CNT_W'(BIT_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(CLK_DIV)) begin
                        sclk_d = 1'b1;
                    end
                    if (cnt_q == CNT_W'(CLK_DIV - 1) && !bitIdx_q[3]) begin
                        shadow_d = {shadow_q[6:0], CIPO_i};
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    cnt_d   = CNT_W'(CS_GAP - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    rsp_d   = shadow_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                ncs_d   = 1'b1;
                sclk_d  = 1'b0;
                copi_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any partial frame and returns pins to idle levels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= 4'd15;
            frame_q  <= 16'd0;
            shadow_q <= 8'd0;
            rsp_q    <= 8'd0;
            sclk_q   <= 1'b0;
            ncs_q    <= 1'b1;
            copi_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            frame_q  <= frame_d;
            shadow_q <= shadow_d;
            rsp_q    <= rsp_d;
            sclk_q   <= sclk_d;
            ncs_q    <= ncs_d;
            copi_q   <= copi_d;
            done_q   <= done_d;
            ready_q  <= (state_d == IDLE);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rsp_data_o  = rsp_q;
    assign SCLK_o      = sclk_q;
    assign nCS_o       = ncs_q;
    assign COPI_o      = copi_q;

endmodule
